// File: rtl/aes_pkg.sv
// Shared constants for the AES round sequencer and the datapath that decodes its phase code.
package aes_pkg;

   // Phase codes, also decoded by the state/key datapath
   localparam logic [2:0] ST_RES = 3'b000;
   localparam logic [2:0] ST_STL = 3'b001;
   localparam logic [2:0] ST_ADD = 3'b010;
   localparam logic [2:0] ST_SUB = 3'b011;
   localparam logic [2:0] ST_SHI = 3'b100;
   localparam logic [2:0] ST_MIX = 3'b101;
   localparam logic [2:0] ST_INV = 3'b110;
   localparam logic [2:0] ST_FIN = 3'b111;

   // Round counts for the three AES key sizes
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   // Request mode encoding
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// Host request/response and datapath control bundle of the AES sequencer.
interface aes_seq_ctrl_if;
   logic       start;
   logic       mode;
   logic       ack;
   logic [2:0] cs;
   logic [3:0] rnd;
   logic       ken;
   logic       kdir;
   logic       busy;
   logic       done;

   modport master (output start, mode, ack,
                   input  cs, rnd, ken, kdir, busy, done);
   modport slave  (input  start, mode, ack,
                   output cs, rnd, ken, kdir, busy, done);
endinterface

// File: rtl/aes_rnd_cnt.sv
// Round-key index counter: clear, load, saturating up/down step, with terminal flags.
module aes_rnd_cnt #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       res,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       at_max,
   output logic       at_zero
);
   localparam logic [3:0] NR_VAL = 4'(NR);

   // Counter never steps past NR going up or below 0 going down, so it cannot wrap
   always_ff @(posedge clk or posedge res) begin
      if (res)
         cnt <= 4'd0;
      else if (clr)
         cnt <= 4'd0;
      else if (load)
         cnt <= load_val;
      else if (inc && (cnt != NR_VAL))
         cnt <= cnt + 4'd1;
      else if (dec && (cnt != 4'd0))
         cnt <= cnt - 4'd1;
   end

   assign at_max  = (cnt == NR_VAL);
   assign at_zero = (cnt == 4'd0);
endmodule

// File: rtl/aes_seq_ctrl.sv
// AES round sequencer: walks the datapath through key pre-expansion (decrypt),
// load, AddRoundKey and Sub/Shift/Mix phases, and steers the key schedule.
module aes_seq_ctrl
   import aes_pkg::*;
#(
   parameter int NR = NR_AES128
) (
   input logic            clk,
   input logic            res,
   aes_seq_ctrl_if.slave  bus
);
   logic [2:0] state;
   logic [2:0] state_next;
   logic       mode_reg;
   logic       mode_next;
   logic       done_reg;
   logic       cnt_clr;
   logic       cnt_load;
   logic       cnt_inc;
   logic       cnt_dec;
   logic [3:0] rnd;
   logic       at_max;
   logic       at_zero;

   aes_rnd_cnt #(.NR(NR)) u_rnd_cnt (
      .clk      (clk),
      .res      (res),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (4'd1),
      .inc      (cnt_inc),
      .dec      (cnt_dec),
      .cnt      (rnd),
      .at_max   (at_max),
      .at_zero  (at_zero)
   );

   // Next phase and round-counter command; encrypt and decrypt walk the round phases in opposite order
   always_comb begin
      state_next = state;
      mode_next  = mode_reg;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         ST_RES: begin
            if (bus.start) begin
               mode_next = bus.mode;
               if (bus.mode == MODE_DEC) begin
                  // Key pre-expansion starts at index 1 so it finishes on NR after NR cycles
                  state_next = ST_INV;
                  cnt_load   = 1'b1;
               end else begin
                  state_next = ST_STL;
                  cnt_clr    = 1'b1;
               end
            end
         end
         ST_INV: begin
            if (at_max) state_next = ST_STL;
            else        cnt_inc    = 1'b1;
         end
         ST_STL: state_next = ST_ADD;
         ST_ADD: begin
            if (mode_reg == MODE_ENC) begin
               if (at_max) state_next = ST_FIN;
               else begin
                  cnt_inc    = 1'b1;
                  state_next = ST_SUB;
               end
            end else begin
               if (at_zero) state_next = ST_FIN;
               else begin
                  cnt_dec    = 1'b1;
                  // First inverse round has no InvMixColumns
                  state_next = at_max ? ST_SHI : ST_MIX;
               end
            end
         end
         ST_SUB: state_next = (mode_reg == MODE_ENC) ? ST_SHI : ST_ADD;
         ST_SHI: begin
            if (mode_reg == MODE_ENC) state_next = at_max ? ST_ADD : ST_MIX;
            else                      state_next = ST_SUB;
         end
         ST_MIX: state_next = (mode_reg == MODE_ENC) ? ST_ADD : ST_SHI;
         ST_FIN: begin
            if (bus.ack) begin
               state_next = ST_RES;
               cnt_clr    = 1'b1;
            end
         end
         default: begin
            state_next = ST_RES;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   // Phase, latched mode and done flag registers
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state    <= ST_RES;
         mode_reg <= MODE_ENC;
         done_reg <= 1'b0;
      end else begin
         state    <= state_next;
         mode_reg <= mode_next;
         done_reg <= (state_next == ST_FIN);
      end
   end

   assign bus.cs   = state;
   assign bus.rnd  = rnd;
   assign bus.done = done_reg;
   assign bus.busy = (state != ST_RES) && (state != ST_FIN);
   // Key steps forward during pre-expansion and encrypt rounds, inverse during decrypt rounds
   assign bus.ken  = (state == ST_INV) ||
                     ((state == ST_ADD) && (mode_reg == MODE_ENC) && !at_max) ||
                     ((state == ST_ADD) && (mode_reg == MODE_DEC) && !at_zero);
   assign bus.kdir = (state == ST_ADD) && (mode_reg == MODE_DEC);
endmodule
